// File: rtl/spi_if.sv
// -----------------------------------------------------------------------------
// spi_if
// Bundles the SPI pins and the RAM-side word/response signals of the SPI slave.
//   SS_n     : slave select, active low (master -> slave)
//   MOSI     : serial data in, MSB first (master -> slave)
//   MISO     : serial read data out, MSB first (slave -> master)
//   rx_data  : completed command word, DATA_W+2 bits (slave -> RAM)
//   rx_valid : one-cycle strobe marking rx_data as new (slave -> RAM)
//   tx_data  : RAM read data (RAM -> slave)
//   tx_valid : RAM read data valid (RAM -> slave)
// The "slave" modport is the spi_slave view. The "master" modport is the view
// of everything around it: the SPI master pins together with the RAM.
// -----------------------------------------------------------------------------
interface spi_if #(
    parameter int DATA_W = 8
);
    logic                SS_n;
    logic                MOSI;
    logic                MISO;
    logic [DATA_W+1:0]   rx_data;
    logic                rx_valid;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Serial-to-parallel front end for the single-port RAM. While SS_n is low it
// shifts DATA_W+2 bits from MOSI into a command word, where bits [9:8] are the
// opcode and the low bits are the address or data. Each completed word goes to
// the RAM together with a one-cycle rx_valid strobe. In a read-data frame the
// slave waits for the RAM response and shifts it out MSB-first on MISO.
// Ports:
//   clk   : system clock, which is also the SPI bit clock (rising edge)
//   rst_n : synchronous active-low reset
//   bus   : spi_if.slave, which carries SS_n, MOSI, MISO, rx_data, rx_valid,
//           tx_data and tx_valid
// The bit counter is 4 bits wide, so DATA_W may be at most 13.
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    spi_if.slave   bus
);
    localparam int         WORD_W      = DATA_W + 2;
    localparam logic [3:0] CNT_WORD    = 4'(WORD_W);
    localparam logic [3:0] CNT_LAST_RX = 4'(WORD_W - 1);
    localparam logic [3:0] CNT_LAST_TX = 4'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t              state;
    logic                rd_addr_flag;
    logic [3:0]          cnt;
    logic [WORD_W-2:0]   rx_shift;    // bits received so far; the last bit comes straight from MOSI
    logic [DATA_W-1:0]   tx_shift;
    logic                tx_active;   // READ_DATA: the response is being shifted out
    logic                tx_done;     // READ_DATA: the response has been shifted out completely
    logic                miso_q;
    logic [WORD_W-1:0]   rx_data_q;
    logic                rx_valid_q;

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    // NOTE: every register is clocked with non-blocking assignments. Each
    // branch then sees the values from before the edge, whatever the
    // statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the reset is synchronous and clears every register. There
            // is no storage array here that could be left unreset.
            state        <= IDLE;
            rd_addr_flag <= 1'b0;
            cnt          <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            tx_active    <= 1'b0;
            tx_done      <= 1'b0;
            miso_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low on every edge. The word-complete
            // branch below overrides it for exactly one cycle.
            rx_valid_q <= 1'b0;

            if (bus.SS_n) begin
                // Deselect wins over every other transition. rd_addr_flag is
                // kept, so an aborted frame leaves the read sequence intact.
                state     <= IDLE;
                cnt       <= '0;
                miso_q    <= 1'b0;
                tx_active <= 1'b0;
                tx_done   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= CHK_CMD;
                    end

                    CHK_CMD: begin
                        rx_shift <= {{(WORD_W-2){1'b0}}, bus.MOSI};
                        cnt      <= 4'd1;
                        if (!bus.MOSI)
                            state <= WRITE;
                        else if (rd_addr_flag)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end

                    WRITE, READ_ADD, READ_DATA: begin
                        if (cnt < CNT_WORD && !tx_active && !tx_done) begin
                            // Receive phase. After the last bit, cnt stays at
                            // CNT_WORD, so any later MOSI bits are ignored.
                            cnt      <= cnt + 4'd1;
                            rx_shift <= {rx_shift[WORD_W-3:0], bus.MOSI};
                            if (cnt == CNT_LAST_RX) begin
                                rx_data_q  <= {rx_shift, bus.MOSI};
                                rx_valid_q <= 1'b1;
                                if (state == READ_ADD)
                                    rd_addr_flag <= 1'b1;
                            end
                        end else if (state == READ_DATA && !tx_done) begin
                            if (!tx_active) begin
                                // Wait for the RAM. The MSB goes out on the
                                // capture edge itself, so the bit order on
                                // MISO is 7..0 across the next DATA_W cycles.
                                if (bus.tx_valid) begin
                                    tx_shift  <= {bus.tx_data[DATA_W-2:0], 1'b0};
                                    miso_q    <= bus.tx_data[DATA_W-1];
                                    cnt       <= '0;
                                    tx_active <= 1'b1;
                                end
                            end else if (cnt == CNT_LAST_TX) begin
                                miso_q       <= 1'b0;
                                tx_active    <= 1'b0;
                                tx_done      <= 1'b1;
                                rd_addr_flag <= 1'b0;
                            end else begin
                                miso_q   <= tx_shift[DATA_W-1];
                                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                                cnt      <= cnt + 4'd1;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave. A small RAM model answers every 11-opcode word
// with tx_data = 8'hA5, one cycle after the rx_valid strobe.
// -----------------------------------------------------------------------------
module tb_spi_slave;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ_ADD  = 3'd3;
    localparam logic [2:0] S_READ_DATA = 3'd4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    spi_if #(.DATA_W(8)) bus ();

    spi_slave #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: raises tx_valid in the cycle after it sees rx_valid on a read-data word.
    always @(posedge clk) begin
        if (!rst_n)
            bus.tx_valid <= 1'b0;
        else
            bus.tx_valid <= bus.rx_valid && (bus.rx_data[9:8] == 2'b11);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    // Advance to 1 ns after the next rising edge. Inputs are driven and outputs are sampled at that point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop SS_n and shift in a complete word. Returns 1 ns after E10.
    task automatic send_frame(input logic [9:0] word);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        step();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = word[i];
            step();
        end
        bus.MOSI = 1'b0;
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        step();
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b1;
        step();
        step();
        rst_n    = 1'b1;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b1;
        step();
        step();
        checks++;
        if (bus.rx_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_rx_data: got %h expected 000", bus.rx_data);
        end
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid);
        end
        checks++;
        if (bus.MISO !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso: got %b expected 0", bus.MISO);
        end
        checks++;
        if (dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, S_IDLE);
        end
        checks++;
        if (dut.rd_addr_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_addr_flag: got %b expected 0", dut.rd_addr_flag);
        end
        rst_n    = 1'b1;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        step();
    endtask

    task automatic test_write();
        logic [9:0] word;
        logic       exp_v;
        word     = 10'b00_0011_0110;
        bus.SS_n = 1'b0;
        step();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = word[i];
            step();
            exp_v = (i == 0);
            checks++;
            if (bus.rx_valid !== exp_v) begin
                errors++;
                $display("FAIL write_rx_valid bit%0d: got %b expected %b", i, bus.rx_valid, exp_v);
            end
            checks++;
            if (bus.MISO !== 1'b0) begin
                errors++;
                $display("FAIL write_miso bit%0d: got %b expected 0", i, bus.MISO);
            end
        end
        checks++;
        if (bus.rx_data !== 10'h036) begin
            errors++;
            $display("FAIL write_rx_data: got %h expected 036", bus.rx_data);
        end
        step();
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_rx_valid_e11: got %b expected 0", bus.rx_valid);
        end
        end_frame();
        checks++;
        if (dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL write_state_after: got %0d expected %0d", dut.state, S_IDLE);
        end
    endtask

    task automatic test_read_sequence();
        logic [7:0] exp_byte;
        exp_byte = 8'hA5;
        send_frame(10'b10_0000_0101);
        checks++;
        if (bus.rx_data !== 10'h205 || bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rdseq_addr_word: got %h/%b expected 205/1", bus.rx_data, bus.rx_valid);
        end
        end_frame();
        checks++;
        if (dut.rd_addr_flag !== 1'b1) begin
            errors++;
            $display("FAIL rdseq_flag_set: got %b expected 1", dut.rd_addr_flag);
        end
        send_frame(10'b11_0000_0000);
        checks++;
        if (bus.rx_data !== 10'h300 || bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rdseq_data_word: got %h/%b expected 300/1", bus.rx_data, bus.rx_valid);
        end
        step();
        checks++;
        if (bus.MISO !== 1'b0) begin
            errors++;
            $display("FAIL rdseq_miso_e11: got %b expected 0", bus.MISO);
        end
        for (int i = 7; i >= 0; i--) begin
            step();
            checks++;
            if (bus.MISO !== exp_byte[i]) begin
                errors++;
                $display("FAIL rdseq_miso_bit%0d: got %b expected %b", i, bus.MISO, exp_byte[i]);
            end
        end
        step();
        checks++;
        if (bus.MISO !== 1'b0) begin
            errors++;
            $display("FAIL rdseq_miso_e20: got %b expected 0", bus.MISO);
        end
        checks++;
        if (dut.rd_addr_flag !== 1'b0) begin
            errors++;
            $display("FAIL rdseq_flag_clear: got %b expected 0", dut.rd_addr_flag);
        end
        end_frame();
    endtask

    task automatic test_read_no_addr();
        apply_reset();
        bus.SS_n = 1'b0;
        step();
        bus.MOSI = 1'b1;
        step();
        checks++;
        if (dut.state !== S_READ_ADD) begin
            errors++;
            $display("FAIL noaddr_state: got %0d expected %0d", dut.state, S_READ_ADD);
        end
        end_frame();
        send_frame(10'b11_1010_1011);
        checks++;
        if (bus.rx_data !== 10'h3AB || bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL noaddr_word: got %h/%b expected 3ab/1", bus.rx_data, bus.rx_valid);
        end
        checks++;
        if (dut.rd_addr_flag !== 1'b1) begin
            errors++;
            $display("FAIL noaddr_flag: got %b expected 1", dut.rd_addr_flag);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (bus.MISO !== 1'b0) begin
                errors++;
                $display("FAIL noaddr_miso cycle%0d: got %b expected 0", i, bus.MISO);
            end
        end
        end_frame();
    endtask

    task automatic test_abort_write();
        logic [9:0] word;
        word     = 10'b00_0101_0101;
        bus.SS_n = 1'b0;
        step();
        for (int i = 9; i >= 4; i--) begin
            bus.MOSI = word[i];
            step();
        end
        bus.SS_n = 1'b1;
        step();
        checks++;
        if (dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL abort_state: got %0d expected %0d", dut.state, S_IDLE);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_rx_valid cycle%0d: got %b expected 0", i, bus.rx_valid);
            end
            step();
        end
        checks++;
        if (bus.rx_data !== 10'h3AB) begin
            errors++;
            $display("FAIL abort_rx_data: got %h expected 3ab", bus.rx_data);
        end
        checks++;
        if (dut.rd_addr_flag !== 1'b1) begin
            errors++;
            $display("FAIL abort_flag: got %b expected 1", dut.rd_addr_flag);
        end
        send_frame(10'b00_1010_1010);
        checks++;
        if (bus.rx_data !== 10'h0AA || bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_frame: got %h/%b expected 0aa/1", bus.rx_data, bus.rx_valid);
        end
        end_frame();
    endtask

    task automatic test_abort_miso();
        send_frame(10'b11_1100_0000);
        checks++;
        if (dut.state !== S_READ_DATA) begin
            errors++;
            $display("FAIL abtx_state: got %0d expected %0d", dut.state, S_READ_DATA);
        end
        step();
        step();
        checks++;
        if (bus.MISO !== 1'b1) begin
            errors++;
            $display("FAIL abtx_bit7: got %b expected 1", bus.MISO);
        end
        step();
        checks++;
        if (bus.MISO !== 1'b0) begin
            errors++;
            $display("FAIL abtx_bit6: got %b expected 0", bus.MISO);
        end
        step();
        checks++;
        if (bus.MISO !== 1'b1) begin
            errors++;
            $display("FAIL abtx_bit5: got %b expected 1", bus.MISO);
        end
        bus.SS_n = 1'b1;
        step();
        checks++;
        if (bus.MISO !== 1'b0) begin
            errors++;
            $display("FAIL abtx_miso_after: got %b expected 0", bus.MISO);
        end
        checks++;
        if (dut.rd_addr_flag !== 1'b1) begin
            errors++;
            $display("FAIL abtx_flag: got %b expected 1", dut.rd_addr_flag);
        end
        bus.SS_n = 1'b0;
        step();
        bus.MOSI = 1'b1;
        step();
        checks++;
        if (dut.state !== S_READ_DATA) begin
            errors++;
            $display("FAIL abtx_next_state: got %0d expected %0d", dut.state, S_READ_DATA);
        end
        end_frame();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.SS_n    = 1'b1;
        bus.MOSI    = 1'b0;
        bus.tx_data = 8'hA5;
        test_reset();
        test_write();
        test_read_sequence();
        test_read_no_addr();
        test_abort_write();
        test_abort_miso();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

Serial-to-parallel front end that feeds the single-port RAM in the SPI-slave/RAM subsystem. It samples the MOSI line while SS_n is low and assembles 10-bit command words: bits [9:8] are the opcode and bits [7:0] are the address or data. It presents each completed word to the RAM with a one-cycle rx_valid strobe. For read-data frames it captures the RAM's tx_data/tx_valid response and shifts it out MSB-first on MISO.

## Interface
- DATA_W, default 8: RAM data/address width. The command word is DATA_W+2 bits.
- clk  in  1  system clock; also the SPI bit clock. MOSI and SS_n are sampled on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- SS_n  in  1  slave select, active low. Low frames one transaction.
- MOSI  in  1  serial data from the master, MSB first.
- MISO  out  1  serial read data to the master, MSB first.
- rx_data  out  DATA_W+2  last completed command word, driven to the RAM din.
- rx_valid  out  1  one-cycle strobe marking rx_data as new.
- tx_data  in  DATA_W  RAM read data (RAM dout).
- tx_valid  in  1  RAM read data valid.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal state: rd_addr_flag (1 bit), bit counter cnt (4 bits), receive shift register, transmit shift register.
- SS_n high sampled in any state sends the FSM to IDLE on that edge. This rule takes priority over every other transition.
- IDLE -> CHK_CMD when SS_n is sampled low.
- CHK_CMD samples MOSI as word bit 9 into the shift register and sets cnt=1.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_flag=0 -> READ_ADD.
  - MOSI=1 and rd_addr_flag=1 -> READ_DATA.
- Receive phase, common to WRITE, READ_ADD and READ_DATA:
  - Each edge shifts MOSI in and increments cnt.
  - The edge that samples the 10th bit (cnt==9) loads rx_data with the full word and sets rx_valid=1 for exactly one cycle.
  - Later MOSI bits in the frame are ignored.
- Bit 8 and the payload are forwarded exactly as received. The slave does not re-check the opcode; only the first bit and rd_addr_flag select the state.
- WRITE: after the word completes, hold until SS_n rises.
- READ_ADD: set rd_addr_flag=1 on the word-complete edge, then hold until SS_n rises.
- READ_DATA:
  - After the word completes, wait for tx_valid. There is no timeout; SS_n high aborts the wait.
  - On the edge where tx_valid=1, load the transmit shift register with tx_data and set cnt=0.
  - The next DATA_W edges shift MISO out, bit 7 first.
  - After the last bit: MISO=0, rd_addr_flag=0, hold until SS_n rises.
- tx_valid is ignored outside the READ_DATA wait.
- An aborted frame (SS_n high before the 10th bit):
  - produces no rx_valid strobe,
  - leaves rx_data unchanged,
  - leaves rd_addr_flag unchanged.
- An aborted READ_DATA transmit also leaves rd_addr_flag set.

## Timing
- Reset values: FSM=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_flag=0, cnt=0, both shift registers 0.
- Reset mid-frame has the same effect as a reset from idle; no strobe is emitted.
- Frame latency, with edge E0 the one sampling SS_n low:
  - E1 samples bit 9.
  - E10 samples bit 0.
  - rx_valid is high during the cycle after E10 (E10 to E11).
- RAM read turnaround: the RAM raises tx_valid in the cycle after it sees rx_valid. The slave captures the data at E12.
- MISO bit 7 is valid E12–E13, and bit 0 is valid E19–E20.
- rx_valid is never high for two consecutive cycles.
- MISO is registered and is 0 whenever no bit is being shifted.
- Consecutive frames need at least one cycle of SS_n high between them. The shortest write frame occupies 11 edges from SS_n low.

## Test plan
- Reset: hold rst_n=0 for 2 cycles while SS_n=0 and MOSI=1 -> rx_data=0, rx_valid=0, MISO=0, FSM stays in IDLE; after release, the first frame behaves normally.
- Write address: SS_n low, shift 00_0011_0110 -> rx_data=0x036 with rx_valid high for one cycle at E10+1; MISO stays 0.
- Read sequence: send 10_0000_0101, raise SS_n, then send 11_0000_0000 with the model RAM returning tx_data=0xA5 one cycle after rx_valid.
  - Expect rx_data=0x205, then 0x300.
  - MISO over E12..E19 is 1,0,1,0,0,1,0,1.
  - rd_addr_flag clears afterwards.
- Read data with no prior read address: after reset, send 11_xxxx_xxxx -> FSM enters READ_ADD, rx_data=0x3xx, rd_addr_flag=1, no MISO activity.
- Abort: raise SS_n after 6 bits of a write frame -> no rx_valid, rx_data unchanged, FSM in IDLE on the next edge; the next full frame is received correctly.
- Abort during MISO shift: raise SS_n after 3 bits out -> MISO=0 on the next edge; the next read command enters READ_DATA (rd_addr_flag still 1).
